// File: rtl/register_file.sv
// register_file: two-read, one-write register array with optional zero register and write bypass
//   clk, reset             : rising-edge clock, synchronous active-high clear of every register
//   wr_en/wr_addr/wr_data  : clocked write port
//   rd_addr1/rd_data1      : combinational read port 1
//   rd_addr2/rd_data2      : combinational read port 2
module register_file #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr1,
  input  logic [ADDR_BITS-1:0] rd_addr2,
  output logic [WIDTH-1:0]     rd_data1,
  output logic [WIDTH-1:0]     rd_data2
);
  localparam int DEPTH = 2**ADDR_BITS;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_ok, w_byp1, w_byp2, w_zero1, w_zero2;
  assign w_wr_ok = wr_en && !(ZERO_REG && wr_addr == '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end
  // bypass is held off during reset so a reset cycle shows stored contents
  always_comb begin
    w_zero1  = ZERO_REG && rd_addr1 == '0;
    w_zero2  = ZERO_REG && rd_addr2 == '0;
    w_byp1   = BYPASS && !reset && wr_en && rd_addr1 == wr_addr;
    w_byp2   = BYPASS && !reset && wr_en && rd_addr2 == wr_addr;
    rd_data1 = w_zero1 ? '0 : w_byp1 ? wr_data : r_mem[rd_addr1];
    rd_data2 = w_zero2 ? '0 : w_byp2 ? wr_data : r_mem[rd_addr2];
  end
endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port register file that generalises the team's single 32-bit write-enabled register into an addressable array. It has two combinational read ports, one clocked write port, an optional hard-wired zero register and an optional write-to-read bypass. It sits in the CPU datapath between instruction decode (register addresses) and the ALU/writeback stage.

## Interface
- WIDTH, 32, data width of each register in bits
- ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS registers
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears every register
- wr_en  input  1  write enable (sampled at rising clk)
- wr_addr  input  ADDR_BITS  write register index
- wr_data  input  WIDTH  write data
- rd_addr1  input  ADDR_BITS  read port 1 index
- rd_addr2  input  ADDR_BITS  read port 2 index
- rd_data1  output  WIDTH  read port 1 data (combinational)
- rd_data2  output  WIDTH  read port 2 data (combinational)

## Operation
- Storage: DEPTH x WIDTH flip-flops; no other state.
- Rising clk with reset=1: all DEPTH registers <= 0; wr_en ignored (reset dominates write).
- Rising clk with reset=0, wr_en=1: mem[wr_addr] <= wr_data, except wr_addr==0 when ZERO_REG=1 (write discarded).
- Rising clk with reset=0, wr_en=0: no register changes.
- Read port n (n=1,2), evaluated combinationally, priority order:
  - ZERO_REG=1 and rd_addrn==0 -> 0
  - BYPASS=1, reset=0, wr_en=1, rd_addrn==wr_addr -> wr_data
  - otherwise -> mem[rd_addrn]
- Ports are independent: both may address the same register, including the one being written; each obeys the rules above.
- Bypass is suppressed while reset=1, so reads show stored contents during a reset cycle.
- With ZERO_REG=0, register 0 is an ordinary register (writable, bypassable).
- No width conversion: wr_data stored verbatim; all addresses in range by construction (DEPTH is a power of two).

## Timing
- Write latency: 1 cycle; a value written at edge k is visible via mem path after edge k.
- Read latency: 0 cycles (combinational from rd_addr, and with BYPASS from wr_en/wr_addr/wr_data).
- Reset: one rising edge with reset=1 clears everything. Before the first reset edge contents are undefined (X). After it, rd_data1/rd_data2 = 0 for every address.
- Reset asserted mid-operation: the pending write in that cycle is lost; contents are 0 after the edge.
- Back-to-back writes to the same address: the last edge wins; no hazards.
- Simultaneous write and read of the same address at the edge: with BYPASS=0 the read shows the old value until the edge and the new value after it.

## Test plan
- Reset then read: reset=1 for one edge, then rd_addr1=5, rd_addr2=31 -> rd_data1=0, rd_data2=0.
- Basic write/hold: wr_en=1, wr_addr=3, wr_data=32'h000090F7, edge; then wr_en=0, wr_data=32'h0000FB50, edge -> rd_addr1=3 reads 32'h000090F7 both cycles after the first edge.
- Zero register: wr_en=1, wr_addr=0, wr_data=32'hDEADBEEF, edge -> rd_data1=0 at rd_addr1=0. With ZERO_REG=0 the same stimulus reads 32'hDEADBEEF.
- Bypass: r7 holds 32'h11111111; wr_en=1, wr_addr=7, wr_data=32'h12345678, rd_addr1=rd_addr2=7 before the edge -> both read 32'h12345678 (BYPASS=1) or 32'h11111111 (BYPASS=0); after the edge both read 32'h12345678.
- Reset dominates write: r4=32'hAAAAAAAA; reset=1, wr_en=1, wr_addr=4, wr_data=32'hFFFFFFFF, edge -> r4 reads 0; rd_data during the reset cycle shows 32'hAAAAAAAA (no bypass).
- Full sweep: write addr*32'h01010101 to addresses 1..31 on consecutive edges, then read pairs (i, 31-i) -> each port returns its address pattern and r0 reads 0.
